div_hilo_ctrl: RTL and testbench
================================

DIV_HILO_CTRL -- requirements
Module: div_hilo_ctrl

Interface
REQ-001 Parameter DIV0_LO, default 32'hFFFF_FFFF: LO value written on divide-by-zero.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 resetn  input  1  asynchronous, active-low reset; the same resetn also drives the divider.
REQ-004 i_req_valid  input  1  divide request from the execute stage.
REQ-005 i_dividend, i_divisor  input  32 each  request operands.
REQ-006 i_is_unsigned  input  1  1 = DIVU, 0 = DIV.
REQ-007 o_req_ready  output  1  high only in IDLE; a request is accepted when i_req_valid && o_req_ready.
REQ-008 i_flush  input  1  cancels the in-flight divide; its result is discarded.
REQ-009 i_mthi, i_mtlo  input  1 each  move-to-HI/LO strobes; i_mt_data  input  32  their data.
REQ-010 i_hilo_read  input  1  an MFHI/MFLO is in decode.
REQ-011 o_hi, o_lo  output  32 each  architectural HI/LO registers.
REQ-012 o_stall  output  1  pipeline stall request.
REQ-013 o_done  output  1  one-cycle pulse in the cycle HI/LO are written by a divide.
REQ-014 o_div_start, o_div_unsigned  output  1 each; o_div_dividend, o_div_divisor  output  32 each  divider launch port (registered).
REQ-015 i_div_quotient, i_div_remainder  input  32 each; i_div_busy  input  1  divider result and status.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT, DRAIN, ZERO.
REQ-017 IDLE with an accepted request and i_divisor != 0: latch operands into the o_div_* registers; go to START.
REQ-018 IDLE with an accepted request and i_divisor == 0: go to ZERO; the divider is not started.
REQ-019 START: o_div_start = 1 for exactly this cycle; go to WAIT unconditionally.
REQ-020 WAIT with i_div_busy = 1: remain in WAIT.
REQ-021 WAIT with i_div_busy = 0: o_done = 1; at the clock edge, LO <= i_div_quotient, HI <= i_div_remainder, and the FSM goes to IDLE.
REQ-022 ZERO: o_done = 1; at the clock edge, LO <= DIV0_LO, HI <= latched dividend, and the FSM goes to IDLE.
REQ-023 Latency for a nonzero divisor, accept edge at end of cycle 0:
  - START in cycle 1;
  - i_div_busy high in cycles 2-33;
  - o_done in cycle 34;
  - new HI/LO and o_req_ready = 1 visible in cycle 35.
REQ-024 Latency for a zero divisor: o_done in cycle 1; HI/LO visible in cycle 2.
REQ-025 i_flush in START or WAIT SHALL move the FSM to DRAIN; START still completes its o_div_start pulse, because the divider cannot abort.
REQ-026 DRAIN SHALL leave HI/LO untouched, hold o_done = 0, and go to IDLE on the edge of the first cycle with i_div_busy = 0, entered from START or otherwise.
REQ-027 i_flush in ZERO SHALL suppress the HI/LO write and o_done; the FSM goes to IDLE.
REQ-028 i_flush in IDLE SHALL block acceptance in that cycle.
REQ-029 i_flush in the WAIT cycle where i_div_busy = 0 SHALL take priority: no write, no o_done.
REQ-030 o_stall = (i_hilo_read | i_mthi | i_mtlo | i_req_valid) && state != IDLE.
REQ-031 In IDLE, i_mthi / i_mtlo SHALL write HI / LO from i_mt_data at the clock edge.
REQ-032 MT writes outside IDLE SHALL be ignored; the source instruction is stalled by REQ-030.
REQ-033 An MT write in IDLE simultaneous with an accepted request SHALL take effect; the later divide result overwrites it.
REQ-034 Signedness is handled inside the divider; the controller passes operands unmodified.

Reset
REQ-035 resetn low, asynchronously:
  - FSM <= IDLE;
  - HI = LO = 0;
  - o_div_dividend, o_div_divisor and o_div_unsigned = 0;
  - o_div_start, o_done and o_stall = 0.
REQ-036 Reset mid-operation SHALL abandon the divide with no HI/LO write.
REQ-037 After resetn releases, o_req_ready SHALL be 1 in the first cycle.

Verification
REQ-038 DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; o_done in cycle 34; ready again in cycle 35.
REQ-039 DIVU 0xFFFFFFFF / 0x10 -> LO = 0x0FFFFFFF, HI = 0x0000000F.
REQ-040 DIV 0x1234 / 0 -> o_done in cycle 1, LO = 0xFFFFFFFF, HI = 0x1234; o_div_start never asserted.
REQ-041 HI = LO = 0x55 before the request; DIV 100 / 7 with i_flush in cycle 10 -> HI/LO stay 0x55, no o_done, o_req_ready returns in cycle 35.
REQ-042 i_hilo_read during WAIT -> o_stall = 1 until cycle 35; i_mthi with 0xAA in IDLE -> o_hi = 0xAA next cycle.
REQ-043 resetn pulsed low in cycle 20 of a divide -> HI = LO = 0, state IDLE, and a new DIV 9 / 3 then gives LO = 3, HI = 0.

Source files
------------

// File: rtl/div_hilo_ctrl.sv
// HI/LO register file and launch/collect controller for an iterative multi-cycle divider.
// Divide-by-zero skips the divider and writes DIV0_LO / the dividend in one cycle.
module div_hilo_ctrl #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req_valid,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_is_unsigned,
  output logic        o_req_ready,
  input  logic        i_flush,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic [31:0] i_mt_data,
  input  logic        i_hilo_read,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_div_start,
  output logic        o_div_unsigned,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  input  logic        i_div_busy
);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StDrain, StZero} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_accept;
  logic        w_div_zero;
  logic        w_wr_div;
  logic        w_wr_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_zero_hi;
  logic [31:0] r_div_dividend;
  logic [31:0] r_div_divisor;
  logic        r_div_unsigned;
  logic        r_div_start;

  always_comb begin
    w_state_next = r_state;
    w_wr_div     = 1'b0;
    w_wr_zero    = 1'b0;
    w_div_zero   = (i_divisor == '0);
    w_accept     = (r_state == StIdle) && i_req_valid && !i_flush;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_div_zero ? StZero : StStart;
      end
      StStart: w_state_next = i_flush ? StDrain : StWait;
      StWait: begin
        // Divider already finished: a flush here only suppresses the write.
        if (!i_div_busy) begin
          w_wr_div     = !i_flush;
          w_state_next = StIdle;
        end else if (i_flush) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (!i_div_busy) w_state_next = StIdle;
      end
      StZero: begin
        w_wr_zero    = !i_flush;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_div_start <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_div_start <= (w_state_next == StStart);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi           <= '0;
      r_lo           <= '0;
      r_zero_hi      <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_div_unsigned <= 1'b0;
    end else begin
      if (r_state == StIdle) begin
        if (i_mthi) r_hi <= i_mt_data;
        if (i_mtlo) r_lo <= i_mt_data;
      end
      if (w_accept && !w_div_zero) begin
        r_div_dividend <= i_dividend;
        r_div_divisor  <= i_divisor;
        r_div_unsigned <= i_is_unsigned;
      end
      if (w_accept && w_div_zero) r_zero_hi <= i_dividend;
      if (w_wr_div) begin
        r_lo <= i_div_quotient;
        r_hi <= i_div_remainder;
      end
      if (w_wr_zero) begin
        r_lo <= DIV0_LO;
        r_hi <= r_zero_hi;
      end
    end
  end

  assign o_req_ready    = (r_state == StIdle);
  assign o_stall        = (i_hilo_read | i_mthi | i_mtlo | i_req_valid) && (r_state != StIdle);
  assign o_done         = w_wr_div | w_wr_zero;
  assign o_hi           = r_hi;
  assign o_lo           = r_lo;
  assign o_div_start    = r_div_start;
  assign o_div_unsigned = r_div_unsigned;
  assign o_div_dividend = r_div_dividend;
  assign o_div_divisor  = r_div_divisor;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: a 32-cycle divider responder, a timestamp-based reference model,
// directed latency/flush/reset scenarios and a randomized run.
module tb_div_hilo_ctrl;

  localparam logic [31:0] DIV0 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, is_unsigned = 1'b0, flush = 1'b0;
  logic        mthi = 1'b0, mtlo = 1'b0, hilo_read = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, mt_data = '0;
  logic        req_ready, stall, done, div_start, div_unsigned, div_busy;
  logic [31:0] hi, lo, div_dividend, div_divisor, div_q, div_r;

  always #5 clk = ~clk;

  div_hilo_ctrl #(.DIV0_LO(DIV0)) dut (
    .clk(clk), .resetn(resetn),
    .i_req_valid(req_valid), .i_dividend(dividend), .i_divisor(divisor),
    .i_is_unsigned(is_unsigned), .o_req_ready(req_ready), .i_flush(flush),
    .i_mthi(mthi), .i_mtlo(mtlo), .i_mt_data(mt_data), .i_hilo_read(hilo_read),
    .o_hi(hi), .o_lo(lo), .o_stall(stall), .o_done(done),
    .o_div_start(div_start), .o_div_unsigned(div_unsigned),
    .o_div_dividend(div_dividend), .o_div_divisor(div_divisor),
    .i_div_quotient(div_q), .i_div_remainder(div_r), .i_div_busy(div_busy)
  );

  function automatic logic [31:0] ref_quot(logic [31:0] a, logic [31:0] b, logic u);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return '0;
    if (u) return a / b;
    return sa / sb;
  endfunction

  function automatic logic [31:0] ref_rem(logic [31:0] a, logic [31:0] b, logic u);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return '0;
    if (u) return a % b;
    return sa % sb;
  endfunction

  // Divider responder: busy for 32 cycles after the start pulse, shares resetn.
  logic [5:0]  d_cnt;
  logic [31:0] d_q, d_r;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_cnt <= '0;
      d_q   <= '0;
      d_r   <= '0;
    end else if (div_start) begin
      d_cnt <= 6'd32;
      d_q   <= ref_quot(div_dividend, div_divisor, div_unsigned);
      d_r   <= ref_rem(div_dividend, div_divisor, div_unsigned);
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 6'd1;
    end
  end
  assign div_busy = (d_cnt != 0);
  assign div_q    = d_q;
  assign div_r    = d_r;

  int n_checks = 0, n_errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request schedules its done/ready cycles and result.
  int          cyc = 0;
  int          m_free_at, m_done_at, m_start_at;
  bit          m_cancel;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo, m_op_a, m_op_b;
  logic        m_op_u;

  int c0 = 0;
  int start_cnt, done_cnt;
  bit obs_done[64], obs_ready[64], obs_stall[64];

  task automatic model_reset();
    m_hi = '0; m_lo = '0;
    m_free_at = cyc; m_done_at = -1; m_start_at = -1; m_cancel = 0;
  endtask

  task automatic check_cycle();
    logic e_ready, e_done, e_stall, e_start;
    int rel;
    e_ready = (cyc >= m_free_at);
    e_done  = (cyc == m_done_at) && !m_cancel && !flush;
    e_stall = (hilo_read | mthi | mtlo | req_valid) && !e_ready;
    e_start = (cyc == m_start_at);
    chk("ready", {31'b0, req_ready}, {31'b0, e_ready});
    chk("done", {31'b0, done}, {31'b0, e_done});
    chk("stall", {31'b0, stall}, {31'b0, e_stall});
    chk("div_start", {31'b0, div_start}, {31'b0, e_start});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (e_start) begin
      chk("div_dividend", div_dividend, m_op_a);
      chk("div_divisor", div_divisor, m_op_b);
      chk("div_unsigned", {31'b0, div_unsigned}, {31'b0, m_op_u});
    end
    rel = cyc - c0;
    if (rel >= 0 && rel < 64) begin
      obs_done[rel]  = done;
      obs_ready[rel] = req_ready;
      obs_stall[rel] = stall;
    end
    if (div_start) start_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic model_edge();
    bit ready;
    ready = (cyc >= m_free_at);
    if (cyc == m_done_at && !m_cancel && !flush) begin
      m_hi = m_rhi;
      m_lo = m_rlo;
    end
    if (flush && !ready) m_cancel = 1;
    if (ready) begin
      if (mthi) m_hi = mt_data;
      if (mtlo) m_lo = mt_data;
      if (req_valid && !flush) begin
        m_op_a = dividend; m_op_b = divisor; m_op_u = is_unsigned; m_cancel = 0;
        if (divisor != 0) begin
          m_start_at = cyc + 1; m_done_at = cyc + 34; m_free_at = cyc + 35;
          m_rlo = ref_quot(dividend, divisor, is_unsigned);
          m_rhi = ref_rem(dividend, divisor, is_unsigned);
        end else begin
          m_done_at = cyc + 1; m_free_at = cyc + 2;
          m_rlo = DIV0; m_rhi = dividend;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic clear_obs();
    c0 = cyc; start_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      obs_done[i] = 0; obs_ready[i] = 0; obs_stall[i] = 0;
    end
  endtask

  // Request in relative cycle 0, optional flush cycle and hilo_read start cycle.
  task automatic run_div(logic [31:0] a, logic [31:0] b, logic u, int flush_at, int read_from,
                         int ncyc);
    clear_obs();
    for (int k = 0; k < ncyc; k++) begin
      req_valid = (k == 0); dividend = a; divisor = b; is_unsigned = u;
      flush = (k == flush_at);
      hilo_read = (read_from >= 0) && (k >= read_from);
      step();
    end
    req_valid = 0; flush = 0; hilo_read = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_div_start", {31'b0, div_start}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_div_dividend", div_dividend, 32'h0);
    chk("rst_div_divisor", div_divisor, 32'h0);
    chk("rst_div_unsigned", {31'b0, div_unsigned}, 32'h0);
  endtask

  task automatic do_reset();
    resetn = 0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    resetn = 1;
  endtask

  initial begin
    req_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    req_valid = 0;
    resetn = 1;
    model_reset();
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);

    // DIV -7 / 2 with an MFHI held in decode from cycle 20.
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1, 20, 40);
    chk("neg_lo", lo, 32'hFFFF_FFFD);
    chk("neg_hi", hi, 32'hFFFF_FFFF);
    chk("neg_done34", {31'b0, obs_done[34]}, 32'h1);
    chk("neg_done_cnt", done_cnt, 1);
    chk("neg_ready34", {31'b0, obs_ready[34]}, 32'h0);
    chk("neg_ready35", {31'b0, obs_ready[35]}, 32'h1);
    chk("neg_stall34", {31'b0, obs_stall[34]}, 32'h1);
    chk("neg_stall35", {31'b0, obs_stall[35]}, 32'h0);

    run_div(32'hFFFF_FFFF, 32'h10, 1'b1, -1, -1, 37);
    chk("divu_lo", lo, 32'h0FFF_FFFF);
    chk("divu_hi", hi, 32'h0000_000F);

    run_div(32'h1234, 32'h0, 1'b0, -1, -1, 4);
    chk("zero_done1", {31'b0, obs_done[1]}, 32'h1);
    chk("zero_ready2", {31'b0, obs_ready[2]}, 32'h1);
    chk("zero_no_start", start_cnt, 0);
    chk("zero_lo", lo, 32'hFFFF_FFFF);
    chk("zero_hi", hi, 32'h0000_1234);

    mthi = 1; mtlo = 1; mt_data = 32'h55;
    step();
    mthi = 0; mtlo = 0;
    run_div(32'd100, 32'd7, 1'b0, 10, -1, 38);
    chk("flush_hi", hi, 32'h55);
    chk("flush_lo", lo, 32'h55);
    chk("flush_no_done", done_cnt, 0);
    chk("flush_ready34", {31'b0, obs_ready[34]}, 32'h0);
    chk("flush_ready35", {31'b0, obs_ready[35]}, 32'h1);

    mthi = 1; mt_data = 32'hAA;
    step();
    mthi = 0;
    chk("mthi_aa", hi, 32'hAA);

    run_div(32'd100, 32'd7, 1'b0, -1, -1, 20);
    do_reset();
    chk("midrst_ready", {31'b0, req_ready}, 32'h1);
    run_div(32'd9, 32'd3, 1'b0, -1, -1, 37);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);

    for (int n = 0; n < 2500; n++) begin
      logic [31:0] a, b;
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 200);
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'h1;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      is_unsigned = $urandom_range(0, 1);
      if (!is_unsigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
      dividend = a; divisor = b;
      req_valid = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 49) == 0);
      mthi = ($urandom_range(0, 9) == 0);
      mtlo = ($urandom_range(0, 9) == 0);
      mt_data = $urandom;
      hilo_read = ($urandom_range(0, 3) == 0);
      if (n == 1300) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
